// File: rtl/xm23_alu_pkg.sv
// xm23_alu_pkg -- shared constants for the XM23 ALU.
// Holds the 5-bit operation codes, the PSW flag bit positions and the
// position of the word/byte select inside alu_op.
package xm23_alu_pkg;

   localparam int OP_W  = 6;
   localparam int PSW_W = 16;

   // alu_op[5] selects byte mode when set
   localparam int WB_BIT = 5;

   // PSW flag positions
   localparam int PSW_C   = 0;
   localparam int PSW_Z   = 1;
   localparam int PSW_N   = 2;
   localparam int PSW_SLP = 3;
   localparam int PSW_V   = 4;

   // Operation codes (alu_op[4:0])
   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_ADDC = 5'd1;
   localparam logic [4:0] OP_SUB  = 5'd2;
   localparam logic [4:0] OP_SUBC = 5'd3;
   localparam logic [4:0] OP_DADD = 5'd4;
   localparam logic [4:0] OP_CMP  = 5'd5;
   localparam logic [4:0] OP_XOR  = 5'd6;
   localparam logic [4:0] OP_AND  = 5'd7;
   localparam logic [4:0] OP_OR   = 5'd8;
   localparam logic [4:0] OP_BIT  = 5'd9;
   localparam logic [4:0] OP_BIC  = 5'd10;
   localparam logic [4:0] OP_BIS  = 5'd11;
   localparam logic [4:0] OP_MOV  = 5'd12;
   localparam logic [4:0] OP_SWAP = 5'd13;
   localparam logic [4:0] OP_SRA  = 5'd14;
   localparam logic [4:0] OP_RRC  = 5'd15;
   localparam logic [4:0] OP_SWPB = 5'd16;
   localparam logic [4:0] OP_SXT  = 5'd17;

   // SWPB and SXT always operate on the full word regardless of W/B
   function automatic logic is_word_only(input logic [4:0] op);
      return (op == OP_SWPB) || (op == OP_SXT);
   endfunction

endpackage

// File: rtl/xm23_alu_if.sv
// xm23_alu_if -- operand/result bundle between the XM23 datapath and its ALU.
//   s_bus, d_bus : source / destination operands
//   alu_op       : {W/B, op[4:0]}
//   psw_in       : current PSW
//   alu_E        : operation enable (one operation per high cycle)
//   psw_update   : commit computed flags
//   alu_out      : registered result
//   psw_out      : registered resulting PSW
// master = datapath/controller side, slave = ALU side.
interface xm23_alu_if #(
   parameter int WIDTH = 16
);
   import xm23_alu_pkg::*;

   logic [WIDTH-1:0] s_bus;
   logic [WIDTH-1:0] d_bus;
   logic [OP_W-1:0]  alu_op;
   logic [PSW_W-1:0] psw_in;
   logic             alu_E;
   logic             psw_update;
   logic [WIDTH-1:0] alu_out;
   logic [PSW_W-1:0] psw_out;

   modport master (
      output s_bus, d_bus, alu_op, psw_in, alu_E, psw_update,
      input  alu_out, psw_out
   );

   modport slave (
      input  s_bus, d_bus, alu_op, psw_in, alu_E, psw_update,
      output alu_out, psw_out
   );

endinterface

// File: rtl/xm23_bcd_adder.sv
// xm23_bcd_adder -- per-nibble decimal adder used by DADD.
//   a, b      : packed BCD operands
//   cin       : decimal carry in (PSW C)
//   byte_mode : only the low two nibbles take part; high byte of a passes through
//   sum       : packed BCD sum
//   cout      : decimal carry out of the top active nibble
module xm23_bcd_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             byte_mode,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIB = WIDTH / 4;

   logic       carry;
   logic       byte_carry;
   logic [4:0] t;

   always_comb begin
      carry      = cin;
      byte_carry = 1'b0;
      t          = '0;
      sum        = a;
      for (int i = 0; i < NIB; i++) begin
         t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
         // a nibble above 9 wraps back into decimal range and carries
         if (t > 5'd9) begin
            t     = t - 5'd10;
            carry = 1'b1;
         end else begin
            carry = 1'b0;
         end
         sum[4*i +: 4] = t[3:0];
         if (i == 1) begin
            byte_carry = carry;
         end
      end
      if (byte_mode) begin
         sum[WIDTH-1:8] = a[WIDTH-1:8];
      end
      cout = byte_mode ? byte_carry : carry;
   end

endmodule

// File: rtl/xm23_alu.sv
// xm23_alu -- registered arithmetic/logic unit of the XM23 datapath.
//   Clock : rising-edge clock
//   reset : synchronous, active-high; clears alu_out and psw_out
//   bus   : xm23_alu_if slave (operands, op, PSW in, enables, registered outputs)
// One operation per cycle with alu_E high; result and PSW appear the next cycle.
module xm23_alu
   import xm23_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic       Clock,
   input  logic       reset,
   xm23_alu_if.slave  bus
);

   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] s;
   logic [4:0]       op;
   logic             byte_mode;
   logic             c_in;

   assign d         = bus.d_bus;
   assign s         = bus.s_bus;
   assign op        = bus.alu_op[4:0];
   assign byte_mode = bus.alu_op[WB_BIT];
   assign c_in      = bus.psw_in[PSW_C];

   function automatic logic msb_of(input logic [WIDTH-1:0] x, input logic bm);
      return bm ? x[7] : x[WIDTH-1];
   endfunction

   function automatic logic is_zero(input logic [WIDTH-1:0] x, input logic bm);
      return bm ? (x[7:0] == 8'h00) : (x == '0);
   endfunction

   // Binary adder shared by ADD/ADDC/SUB/SUBC/CMP. Byte mode masks the
   // operands so the carry out lands on bit 8.
   logic [WIDTH-1:0] lo_mask;
   logic [WIDTH-1:0] b_eff;
   logic             add_cin;
   logic [WIDTH:0]   add_sum;
   logic             add_cout;
   logic             add_v;

   assign lo_mask = byte_mode ? {{(WIDTH-8){1'b0}}, 8'hFF} : '1;

   always_comb begin
      b_eff   = s;
      add_cin = 1'b0;
      case (op)
         OP_ADDC:         add_cin = c_in;
         OP_SUB, OP_CMP:  begin b_eff = ~s; add_cin = 1'b1; end
         OP_SUBC:         begin b_eff = ~s; add_cin = c_in; end
         default:         ;
      endcase
   end

   assign add_sum  = {1'b0, d & lo_mask} + {1'b0, b_eff & lo_mask} + {{WIDTH{1'b0}}, add_cin};
   assign add_cout = byte_mode ? add_sum[8] : add_sum[WIDTH];
   assign add_v    = (msb_of(d, byte_mode) == msb_of(b_eff, byte_mode)) &&
                     (msb_of(add_sum[WIDTH-1:0], byte_mode) != msb_of(d, byte_mode));

   logic [WIDTH-1:0] bcd_sum;
   logic             bcd_cout;

   xm23_bcd_adder #(.WIDTH(WIDTH)) u_bcd (
      .a         (d),
      .b         (s),
      .cin       (c_in),
      .byte_mode (byte_mode),
      .sum       (bcd_sum),
      .cout      (bcd_cout)
   );

   // res drives the flags; out_sel is what gets registered (CMP/BIT keep D)
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] out_sel;
   logic             wr_c, wr_zn, wr_v;
   logic             new_c, new_v;
   logic             eff_byte;
   logic [WIDTH-1:0] alu_res;
   logic [PSW_W-1:0] psw_next;

   always_comb begin
      res     = d;
      out_sel = d;
      wr_c    = 1'b0;
      wr_zn   = 1'b0;
      wr_v    = 1'b0;
      new_c   = c_in;
      new_v   = bus.psw_in[PSW_V];
      case (op)
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
            res = add_sum[WIDTH-1:0]; out_sel = res;
            wr_c = 1'b1; wr_zn = 1'b1; wr_v = 1'b1;
            new_c = add_cout; new_v = add_v;
         end
         OP_CMP: begin
            res = add_sum[WIDTH-1:0];
            wr_c = 1'b1; wr_zn = 1'b1; wr_v = 1'b1;
            new_c = add_cout; new_v = add_v;
         end
         OP_DADD: begin
            res = bcd_sum; out_sel = res;
            wr_c = 1'b1; wr_zn = 1'b1; new_c = bcd_cout;
         end
         OP_XOR:          begin res = d ^ s;  out_sel = res; wr_zn = 1'b1; end
         OP_AND:          begin res = d & s;  out_sel = res; wr_zn = 1'b1; end
         OP_OR, OP_BIS:   begin res = d | s;  out_sel = res; wr_zn = 1'b1; end
         OP_BIT:          begin res = d & s;  wr_zn = 1'b1; end
         OP_BIC:          begin res = d & ~s; out_sel = res; wr_zn = 1'b1; end
         OP_MOV, OP_SWAP: begin res = s;      out_sel = s; end
         OP_SRA: begin
            res = byte_mode ? {d[WIDTH-1:8], d[7], d[7:1]} : {d[WIDTH-1], d[WIDTH-1:1]};
            out_sel = res; wr_c = 1'b1; wr_zn = 1'b1; new_c = d[0];
         end
         OP_RRC: begin
            res = byte_mode ? {d[WIDTH-1:8], c_in, d[7:1]} : {c_in, d[WIDTH-1:1]};
            out_sel = res; wr_c = 1'b1; wr_zn = 1'b1; new_c = d[0];
         end
         OP_SWPB: begin res = {d[7:0], d[WIDTH-1:8]};       out_sel = res; wr_zn = 1'b1; end
         OP_SXT:  begin res = {{(WIDTH-8){d[7]}}, d[7:0]};  out_sel = res; wr_zn = 1'b1; end
         default: ;
      endcase
   end

   assign eff_byte = byte_mode && !is_word_only(op);
   assign alu_res  = eff_byte ? {d[WIDTH-1:8], out_sel[7:0]} : out_sel;

   // Only C/Z/N/V can change; SLP and the opaque upper bits pass through
   always_comb begin
      psw_next = bus.psw_in;
      if (bus.psw_update) begin
         if (wr_c)  psw_next[PSW_C] = new_c;
         if (wr_zn) begin
            psw_next[PSW_Z] = is_zero(res, eff_byte);
            psw_next[PSW_N] = msb_of(res, eff_byte);
         end
         if (wr_v)  psw_next[PSW_V] = new_v;
      end
   end

   // ---- stage p1: registered result and PSW ----
   logic [WIDTH-1:0] res_p1;
   logic [PSW_W-1:0] psw_p1;

   always_ff @(posedge Clock) begin
      if (reset) begin
         res_p1 <= '0;
         psw_p1 <= '0;
      end else if (bus.alu_E) begin
         res_p1 <= alu_res;
         psw_p1 <= psw_next;
      end
   end

   assign bus.alu_out = res_p1;
   assign bus.psw_out = psw_p1;

endmodule

// File: tb/tb_xm23_alu.sv
// tb_xm23_alu -- directed-vector scoreboard bench for xm23_alu.
// The driver issues one vector per cycle and queues the hand-computed
// outputs tagged with the cycle they must appear; the monitor pops and
// compares on the falling edge of that cycle.
module tb_xm23_alu;
   import xm23_alu_pkg::*;

   logic Clock = 1'b0;
   logic reset;

   xm23_alu_if #(.WIDTH(16)) bus ();

   xm23_alu #(.WIDTH(16)) dut (
      .Clock (Clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int          due;
      logic [15:0] out;
      logic [15:0] psw;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   // Monitor
   always @(negedge Clock) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (bus.alu_out !== e.out) begin
            errors++;
            $display("FAIL %s alu_out: got %h expected %h", e.name, bus.alu_out, e.out);
         end
         checks++;
         if (bus.psw_out !== e.psw) begin
            errors++;
            $display("FAIL %s psw_out: got %h expected %h", e.name, bus.psw_out, e.psw);
         end
      end
   end

   task automatic issue(input string nm, input logic rst_i, input logic en,
                        input logic [5:0] op, input logic [15:0] dv, input logic [15:0] sv,
                        input logic [15:0] pin, input logic upd,
                        input logic [15:0] eo, input logic [15:0] ep);
      exp_t e;
      @(posedge Clock);
      #1;
      reset          = rst_i;
      bus.alu_E      = en;
      bus.alu_op     = op;
      bus.d_bus      = dv;
      bus.s_bus      = sv;
      bus.psw_in     = pin;
      bus.psw_update = upd;
      e.due  = cyc + 1;
      e.out  = eo;
      e.psw  = ep;
      e.name = nm;
      sb.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset          = 1'b1;
      bus.alu_E      = 1'b0;
      bus.alu_op     = '0;
      bus.d_bus      = '0;
      bus.s_bus      = '0;
      bus.psw_in     = '0;
      bus.psw_update = 1'b0;

      //     name          rst en  op      d         s         psw_in    upd  exp_out   exp_psw
      issue("reset",       1, 0, 6'h00, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000);
      issue("add_w_ovf",   0, 1, 6'h00, 16'h7FFF, 16'h0001, 16'hA5E8, 1, 16'h8000, 16'hA5FC);
      issue("sub_b_zero",  0, 1, 6'h22, 16'h1234, 16'h0034, 16'hA5F4, 1, 16'h1200, 16'hA5E3);
      issue("sub_b_noupd", 0, 1, 6'h22, 16'h1234, 16'h0034, 16'hA5F4, 0, 16'h1200, 16'hA5F4);
      issue("addc_w_wrap", 0, 1, 6'h01, 16'hFFFF, 16'h0000, 16'h0001, 1, 16'h0000, 16'h0003);
      issue("dadd_w",      0, 1, 6'h04, 16'h0999, 16'h0001, 16'h0010, 1, 16'h1000, 16'h0010);
      issue("sra_w",       0, 1, 6'h0E, 16'h8001, 16'h0000, 16'h0000, 1, 16'hC000, 16'h0005);
      issue("rrc_w",       0, 1, 6'h0F, 16'h0002, 16'h0000, 16'h0001, 1, 16'h8001, 16'h0004);
      issue("sxt_wb_ign",  0, 1, 6'h31, 16'h0080, 16'h0000, 16'h0002, 1, 16'hFF80, 16'h0004);
      issue("swpb_w",      0, 1, 6'h10, 16'h12AB, 16'h0000, 16'h0000, 1, 16'hAB12, 16'h0004);
      issue("cmp_eq",      0, 1, 6'h05, 16'h0005, 16'h0005, 16'h0000, 1, 16'h0005, 16'h0003);
      issue("add_b_carry", 0, 1, 6'h20, 16'h12FF, 16'h0001, 16'h0000, 1, 16'h1200, 16'h0003);
      issue("subc_w_borr", 0, 1, 6'h03, 16'h0000, 16'h0001, 16'h0000, 1, 16'hFFFE, 16'h0004);
      issue("mov_noflag",  0, 1, 6'h0C, 16'h1111, 16'hABCD, 16'h0017, 1, 16'hABCD, 16'h0017);
      issue("reserved",    0, 1, 6'h14, 16'hBEEF, 16'h1234, 16'h0000, 1, 16'hBEEF, 16'h0000);
      issue("bic_w",       0, 1, 6'h0A, 16'hF0F0, 16'hF000, 16'h0011, 1, 16'h00F0, 16'h0011);
      issue("hold1",       0, 0, 6'h00, 16'h5555, 16'h1111, 16'hFFFF, 1, 16'h00F0, 16'h0011);
      issue("hold2",       0, 0, 6'h06, 16'hAAAA, 16'h2222, 16'h0000, 1, 16'h00F0, 16'h0011);
      issue("hold3",       0, 0, 6'h0C, 16'h0F0F, 16'h3333, 16'h1234, 0, 16'h00F0, 16'h0011);
      issue("reset_w_en",  1, 1, 6'h00, 16'h0001, 16'h0001, 16'hFFFF, 1, 16'h0000, 16'h0000);
      issue("add_after",   0, 1, 6'h00, 16'h0001, 16'h0002, 16'h0000, 1, 16'h0003, 16'h0000);

      @(posedge Clock);
      #1;
      bus.alu_E = 1'b0;

      for (int i = 0; i < 20 && sb.size() > 0; i++) begin
         @(posedge Clock);
      end
      if (sb.size() > 0) begin
         errors += sb.size();
         checks += sb.size();
         $display("FAIL drain: %0d expected responses never compared", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
